// File: rtl/types_pkg.sv
// Shared types for the instruction fetch queue:
// controller state encoding and the queue entry layout.
package types_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 16;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
      logic               filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: pc written on allocate,
// instruction and filled bit written on fill, head read combinationally.
module fetch_queue_ram #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4,
   localparam int IW     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               alloc_i,
   input  logic [IW-1:0]      alloc_idx_i,
   input  logic [ADDR_W-1:0]  alloc_pc_i,
   input  logic               fill_i,
   input  logic [IW-1:0]      fill_idx_i,
   input  logic [INSTR_W-1:0] fill_instr_i,
   input  logic               pop_i,
   input  logic [IW-1:0]      rd_idx_i,
   output logic               rd_filled_o,
   output logic [ADDR_W-1:0]  rd_pc_o,
   output logic [INSTR_W-1:0] rd_instr_o
);

   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [DEPTH-1:0]   filled_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
         filled_q <= '0;
      end else begin
         // a flush invalidates every slot; data words may stay stale
         if (flush_i) begin
            filled_q <= '0;
         end else begin
            if (pop_i)   filled_q[rd_idx_i]    <= 1'b0;
            if (alloc_i) filled_q[alloc_idx_i] <= 1'b0;
            if (fill_i)  filled_q[fill_idx_i]  <= 1'b1;
         end
         if (alloc_i) pc_q[alloc_idx_i]   <= alloc_pc_i;
         if (fill_i)  instr_q[fill_idx_i] <= fill_instr_i;
      end
   end

   assign rd_filled_o = filled_q[rd_idx_i];
   assign rd_pc_o     = pc_q[rd_idx_i];
   assign rd_instr_o  = instr_q[rd_idx_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers
// in-order responses and drops responses orphaned by a redirect.
module fetch_queue #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4,
   parameter int PC_STEP = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               halt_sys,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready,
   output logic               halted
);

   import types_pkg::*;

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int IW = PW - 1;
   // back-to-back redirects can stack orphans beyond one queue's worth
   localparam int DW = PW + 2;

   fetch_state_e  state_q, state_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] fill_q, fill_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DW-1:0] drop_q, drop_d;

   logic [PW-1:0] used;
   logic [PW-1:0] unfilled;
   logic [DW-1:0] drop_tot;
   logic run, full, empty, flush;
   logic xfer, pop, fill, head_filled;

   assign used     = wr_q - rd_q;
   assign unfilled = wr_q - fill_q;
   assign full     = (used == PW'(DEPTH));
   assign empty    = (wr_q == rd_q);
   assign run      = (state_q == RUN) && !halt_sys;
   assign flush    = run && redirect;

   assign imem_req  = run && !full && !redirect;
   assign imem_addr = pc_q;
   assign xfer      = imem_req && imem_gnt;

   assign out_valid = run && !empty && head_filled;
   assign pop       = out_valid && out_ready && !redirect;
   assign fill      = run && !redirect && imem_rvalid
                      && (drop_q == '0) && (unfilled != '0);
   assign halted    = (state_q == HALTED);

   assign drop_tot = drop_q + DW'(unfilled);

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      fill_d  = fill_q;
      rd_d    = rd_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_sys) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = BOOT;
      endcase
      if (flush) begin
         rd_d   = wr_q;
         fill_d = wr_q;
         pc_d   = redirect_pc;
         drop_d = drop_tot - DW'(imem_rvalid && (drop_tot != '0));
      end else begin
         if (xfer) begin
            wr_d = wr_q + 1'b1;
            pc_d = pc_q + ADDR_W'(PC_STEP);
         end
         if (fill) fill_d = fill_q + 1'b1;
         if (pop)  rd_d   = rd_q + 1'b1;
         if (run && imem_rvalid && (drop_q != '0))
            drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= BOOT;
         wr_q    <= '0;
         fill_q  <= '0;
         rd_q    <= '0;
         pc_q    <= RESET_PC;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         fill_q  <= fill_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   fetch_queue_ram #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) u_ram (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .alloc_i      (xfer),
      .alloc_idx_i  (wr_q[IW-1:0]),
      .alloc_pc_i   (pc_q),
      .fill_i       (fill),
      .fill_idx_i   (fill_q[IW-1:0]),
      .fill_instr_i (imem_rdata),
      .pop_i        (pop),
      .rd_idx_i     (rd_q[IW-1:0]),
      .rd_filled_o  (head_filled),
      .rd_pc_o      (out_pc),
      .rd_instr_o   (out_instr)
   );

endmodule
